// File: rtl/sram_req_ctrl_pkg.sv
// sram_req_ctrl_pkg: shared grant type and default sizes for the 1RW SRAM request controller
package sram_req_ctrl_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_e;
  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 50;
  localparam int RESP_DEPTH_DEF = 2;
  localparam int PERF_W         = 32;
endpackage

// File: rtl/sram_req_resp_fifo.sv
// sram_req_resp_fifo: wrapping-pointer FIFO holding SRAM read responses
// Ports: clock, reset (sync, active-high); push/din write the tail; pop retires the head;
//        dout is the head word; count/full/empty report occupancy.
module sram_req_resp_fifo import sram_req_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = RESP_DEPTH_DEF,
  localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     count_q;
  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= din;
        wp_q        <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  assign dout  = mem_q[rp_q];
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// sram_1rw_req_ctrl: arbitrates write/read request channels onto a 1RW SRAM and queues read data
// Ports: clock, reset (sync, active-high); wr_valid/wr_ready/wr_addr/wr_data write channel;
//        rd_valid/rd_ready/rd_addr read channel; resp_valid/resp_ready/resp_data response queue head;
//        ram_addr/ram_en/ram_wmode/ram_wdata/ram_rdata macro pins (1-cycle read latency);
//        perf_rd_stall/perf_conflict counters, live only when SRAM_REQ_CTRL_PERF_EN is defined.
module sram_1rw_req_ctrl import sram_req_ctrl_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_wmode,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [PERF_W-1:0] perf_rd_stall,
  output logic [PERF_W-1:0] perf_conflict
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int OW = CW + 1;
  grant_e        gnt;
  logic          inflight_q, rr_rd_q, pop, rd_ok, both, q_full, q_empty;
  logic [CW-1:0] q_count;
  logic [OW-1:0] occ;
  assign resp_valid = !q_empty;
  assign pop        = resp_valid && resp_ready;
  // Reserve a slot for the read in flight; a same-cycle pop frees one.
  assign occ   = {1'b0, q_count} + OW'(inflight_q) - OW'(pop);
  assign rd_ok = occ < OW'(RESP_DEPTH);
  assign both  = wr_valid && rd_valid && rd_ok;
  // rr_rd_q set means the last contested grant went to the read side.
  always_comb begin
    gnt = reset ? GNT_NONE :
          both ? (rr_rd_q ? GNT_WR : GNT_RD) :
          wr_valid ? GNT_WR :
          (rd_valid && rd_ok) ? GNT_RD : GNT_NONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      rr_rd_q    <= 1'b1;
    end else begin
      inflight_q <= gnt == GNT_RD;
      if (both) rr_rd_q <= gnt == GNT_RD;
    end
  end
  assign wr_ready  = gnt == GNT_WR;
  assign rd_ready  = gnt == GNT_RD;
  assign ram_en    = gnt != GNT_NONE;
  assign ram_wmode = gnt == GNT_WR;
  assign ram_addr  = gnt == GNT_WR ? wr_addr : gnt == GNT_RD ? rd_addr : '0;
  assign ram_wdata = gnt == GNT_WR ? wr_data : '0;
  sram_req_resp_fifo #(.DATA_W(DATA_W), .DEPTH(RESP_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (ram_rdata),
    .dout  (resp_data),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(inflight_q && q_full && !pop));
`ifdef SRAM_REQ_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_q, conf_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      conf_q  <= '0;
    end else begin
      if (rd_valid && !rd_ok && ~&stall_q) stall_q <= stall_q + 1'b1;
      if (wr_valid && rd_valid && ~&conf_q) conf_q <= conf_q + 1'b1;
    end
  end
  assign perf_rd_stall = stall_q;
  assign perf_conflict = conf_q;
`else
  assign perf_rd_stall = '0;
  assign perf_conflict = '0;
`endif
endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// tb_sram_1rw_req_ctrl: directed stimulus with a queue-based reference model and literal checkpoints
module tb_sram_1rw_req_ctrl;
  localparam int AW = 6;
  localparam int DW = 50;
  localparam int RD = 2;
  localparam logic [DW-1:0] D1 = 50'h2_AAAA_5555_1234;
  localparam logic [DW-1:0] D2 = 50'h1_0F0F_3C3C_9999;
  localparam logic [DW-1:0] D3 = 50'h3_1234_5678_ABCD;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0, rd_valid = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready, rd_ready, resp_valid, ram_en, ram_wmode;
  logic [DW-1:0] resp_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0] perf_rd_stall, perf_conflict;
  int n_cmp = 0, n_err = 0;
  always #5 clock = ~clock;
  sram_1rw_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(RD)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_wmode(ram_wmode), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .perf_rd_stall(perf_rd_stall), .perf_conflict(perf_conflict)
  );
  // SRAM macro: word i initially holds i.
  logic [DW-1:0] sram [64];
  initial begin
    for (int i = 0; i < 64; i++) sram[i] <= DW'(i);
    ram_rdata <= '0;
  end
  always @(posedge clock)
    if (ram_en) begin
      if (ram_wmode) sram[ram_addr] <= ram_wdata;
      else ram_rdata <= sram[ram_addr];
    end
  // Reference model: contents, response queue, one pending read, fairness bit, perf counts.
  logic [DW-1:0] emem [64];
  logic [DW-1:0] mq [$];
  logic [DW-1:0] pend_d = '0;
  bit pend_v = 0;
  bit rr_rd = 1;
  logic [31:0] pc = '0, ps = '0;
  initial for (int i = 0; i < 64; i++) emem[i] = DW'(i);
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void predict(output bit gw, output bit gr, output bit ok);
    int pop = (mq.size() > 0 && resp_ready) ? 1 : 0;
    ok = (mq.size() + int'(pend_v) - pop) < RD;
    gw = 0;
    gr = 0;
    if (!reset) begin
      if (wr_valid && rd_valid && ok) begin
        gw = rr_rd;
        gr = !rr_rd;
      end else if (wr_valid) gw = 1;
      else if (rd_valid && ok) gr = 1;
    end
  endfunction
  always @(posedge clock) begin
    bit gw, gr, ok;
    predict(gw, gr, ok);
    if (reset) begin
      mq.delete();
      pend_v = 0;
      rr_rd = 1;
      pc = '0;
      ps = '0;
    end else begin
`ifdef SRAM_REQ_CTRL_PERF_EN
      if (wr_valid && rd_valid && ~&pc) pc++;
      if (rd_valid && !ok && ~&ps) ps++;
`endif
      if (wr_valid && rd_valid && ok) rr_rd = gr;
      if (mq.size() > 0 && resp_ready) void'(mq.pop_front());
      if (pend_v) mq.push_back(pend_d);
      if (gr) pend_d = emem[rd_addr];
      pend_v = gr;
      if (gw) emem[wr_addr] = wr_data;
    end
  end
  always @(negedge clock) begin
    bit gw, gr, ok;
    predict(gw, gr, ok);
    chk("wr_ready", wr_ready, gw);
    chk("rd_ready", rd_ready, gr);
    chk("one_grant", wr_ready && rd_ready, 0);
    chk("ram_en", ram_en, gw || gr);
    chk("ram_wmode", ram_wmode, gw);
    if (gw || gr) chk("ram_addr", ram_addr, gw ? wr_addr : rd_addr);
    if (gw) chk("ram_wdata", ram_wdata, wr_data);
    chk("resp_valid", resp_valid, mq.size() > 0);
    if (mq.size() > 0) chk("resp_data", resp_data, mq[0]);
    chk("perf_conflict", perf_conflict, pc);
    chk("perf_rd_stall", perf_rd_stall, ps);
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic neg();
    @(negedge clock);
  endtask
  task automatic rst_pulse();
    reset = 1;
    cyc();
    reset = 0;
  endtask
  function automatic logic [DW-1:0] lit(int a);
    return a == 5 ? D1 : a == 9 ? D2 : DW'(a);
  endfunction
  initial begin
    // Reset holds both readies low even with requests present.
    wr_valid = 1;
    rd_valid = 1;
    cyc();
    neg();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    cyc();
    reset = 0;
    wr_valid = 0;
    rd_valid = 0;
    neg();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_perf_c", perf_conflict, 0);
    chk("rst_perf_s", perf_rd_stall, 0);
    // Write then read back address 5.
    cyc();
    wr_valid = 1; wr_addr = 5; wr_data = D1;
    neg();
    chk("t1_wr_ready", wr_ready, 1);
    chk("t1_ram_addr", ram_addr, 5);
    cyc();
    wr_valid = 0; rd_valid = 1; rd_addr = 5; resp_ready = 1;
    neg();
    chk("t1_rd_ready", rd_ready, 1);
    cyc();
    rd_valid = 0;
    neg();
    chk("t1_lat1_valid", resp_valid, 0);
    cyc();
    neg();
    chk("t1_lat2_valid", resp_valid, 1);
    chk("t1_data", resp_data, D1);
    cyc();
    neg();
    chk("t1_drained", resp_valid, 0);
    // Contested requests alternate starting with the write.
    rst_pulse();
    wr_valid = 1; wr_addr = 9; wr_data = D2; rd_valid = 1; rd_addr = 7;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("t2_wmode", ram_wmode, (k % 2) == 0);
      chk("t2_wr_ready", wr_ready, (k % 2) == 0);
      chk("t2_rd_ready", rd_ready, (k % 2) == 1);
      cyc();
    end
    wr_valid = 0; rd_valid = 0;
    cyc(); cyc(); cyc();
    // Queue full stalls the third read until the first pop.
    rst_pulse();
    resp_ready = 0; rd_valid = 1; rd_addr = 0;
    neg(); chk("t3_rd0", rd_ready, 1); cyc();
    rd_addr = 1;
    neg(); chk("t3_rd1", rd_ready, 1); cyc();
    rd_addr = 2;
    neg(); chk("t3_stall_a", rd_ready, 0); cyc();
    neg(); chk("t3_stall_b", rd_ready, 0); chk("t3_head0", resp_data, 0); cyc();
    resp_ready = 1;
    neg(); chk("t3_rd2", rd_ready, 1); chk("t3_pop0", resp_data, 0); cyc();
    rd_valid = 0;
    neg(); chk("t3_pop1", resp_data, 1); cyc();
    neg(); chk("t3_pop2", resp_data, 2); cyc();
    neg(); chk("t3_empty", resp_valid, 0);
    // Back-to-back reads, one per cycle.
    rst_pulse();
    resp_ready = 1; rd_valid = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = AW'(i);
      neg();
      chk("t4_rd_ready", rd_ready, 1);
      if (i >= 2) begin
        chk("t4_valid", resp_valid, 1);
        chk("t4_data", resp_data, lit(i - 2));
      end
      cyc();
    end
    rd_valid = 0;
    for (int i = 16; i < 18; i++) begin
      neg();
      chk("t4_valid_tail", resp_valid, 1);
      chk("t4_data_tail", resp_data, lit(i - 2));
      cyc();
    end
    neg(); chk("t4_empty", resp_valid, 0);
    // Reset with one queued entry and one read in flight.
    rst_pulse();
    resp_ready = 0; rd_valid = 1; rd_addr = 3;
    neg(); chk("t5_rd3", rd_ready, 1); cyc();
    rd_addr = 4;
    neg(); chk("t5_rd4", rd_ready, 1); cyc();
    reset = 1; rd_addr = 6;
    neg(); chk("t5_q_held", resp_valid, 1); chk("t5_rst_rd_ready", rd_ready, 0); cyc();
    resp_ready = 1;
    neg(); chk("t5_cleared", resp_valid, 0); chk("t5_rst_rd_ready2", rd_ready, 0); cyc();
    reset = 0;
    neg(); chk("t5_rd6", rd_ready, 1); cyc();
    rd_valid = 0;
    neg(); chk("t5_no_stale", resp_valid, 0); cyc();
    neg(); chk("t5_valid", resp_valid, 1); chk("t5_data", resp_data, 6); cyc();
    neg(); chk("t5_empty", resp_valid, 0);
    // Three conflict cycles then two stall cycles.
    rst_pulse();
    resp_ready = 0; wr_valid = 1; wr_addr = 20; wr_data = D3; rd_valid = 1; rd_addr = 21;
    cyc(); cyc(); cyc();
    wr_valid = 0;
    cyc(); cyc(); cyc();
    rd_valid = 0;
    neg();
`ifdef SRAM_REQ_CTRL_PERF_EN
    chk("t6_perf_conflict", perf_conflict, 3);
    chk("t6_perf_rd_stall", perf_rd_stall, 2);
`else
    chk("t6_perf_conflict", perf_conflict, 0);
    chk("t6_perf_rd_stall", perf_rd_stall, 0);
`endif
    resp_ready = 1;
    cyc(); cyc(); cyc(); cyc();
    neg(); chk("t6_empty", resp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
